// File: rtl/rv_div_pkg.sv
// Shared types and elaboration helpers for the rv_divider integer divide unit.
package rv_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_RADIX_BITS = 1;

    // Cycles from the accept cycle to the we_o cycle on the constant-time path.
    function automatic int latency(input int xlen, input int radix_bits);
        return xlen / radix_bits + 2;
    endfunction

    function automatic bit params_ok(input int xlen, input int radix_bits);
        bit xlen_ok;
        bit radix_ok;
        xlen_ok  = (xlen == 16) || (xlen == 32) || (xlen == 64);
        radix_ok = (radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4);
        return xlen_ok && radix_ok && ((xlen % radix_bits) == 0);
    endfunction

endpackage

// File: rtl/rv_divider_if.sv
// Command/result handshake between the issue pipeline and rv_divider.
interface rv_divider_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            cmd_div_i;
    logic            cmd_signed_i;
    logic            cmd_div_mod_i;
    logic            kill_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [XLEN-1:0] result_o;
    logic            we_o;
    logic            busy_o;
    logic            wait_o;

    modport slave (
        input  valid_i, cmd_div_i, cmd_signed_i, cmd_div_mod_i, kill_i, op1_i, op2_i,
        output result_o, we_o, busy_o, wait_o
    );

    modport master (
        output valid_i, cmd_div_i, cmd_signed_i, cmd_div_mod_i, kill_i, op1_i, op2_i,
        input  result_o, we_o, busy_o, wait_o
    );
endinterface

// File: rtl/rv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);
    logic [XLEN+1:0] rem_sh;

    assign rem_sh = {rem_i, dvd_msb_i};
    assign q_o    = (rem_sh >= {2'b00, dvs_i});
    assign rem_o  = q_o ? (rem_sh[XLEN:0] - {1'b0, dvs_i}) : rem_sh[XLEN:0];

endmodule

// File: rtl/rv_divider.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit, RADIX_BITS quotient bits per cycle.
// Build option RV_DIV_EARLY_OUT_EN: trivial cases bypass CALC/FIX (IDLE -> DONE).
//
// state | meaning
// IDLE  | waiting for a request; accepts when request & ~kill
// CALC  | RADIX_BITS restoring steps per cycle, N cycles total
// FIX   | quotient/remainder select and sign correction into result_q
// DONE  | we_o strobe for one cycle, result_o valid
module rv_divider
    import rv_div_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int RADIX_BITS = DEF_RADIX_BITS
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rv_divider_if.slave  div_if
);
    localparam int N     = XLEN / RADIX_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if (!params_ok(XLEN, RADIX_BITS)) begin : g_bad_params
        $error("rv_divider: unsupported XLEN/RADIX_BITS combination");
    end

    div_state_e      state_q, state_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            mod_q, mod_d;
    logic            forced_q, forced_d;

    logic            request;
    logic            accept;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic            early;
    logic [XLEN-1:0] forced_res;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    logic [XLEN:0]         rem_chain [RADIX_BITS+1];
    logic [RADIX_BITS-1:0] q_bits;

    assign request = div_if.valid_i & div_if.cmd_div_i;
    assign accept  = request & ~div_if.kill_i & (state_q == ST_IDLE);

    assign div_if.wait_o   = accept;
    assign div_if.busy_o   = (state_q != ST_IDLE);
    assign div_if.we_o     = (state_q == ST_DONE) & ~div_if.kill_i;
    assign div_if.result_o = div_if.we_o ? result_q : '0;

    // Magnitudes are unsigned, so |-2^(XLEN-1)| is representable without overflow.
    assign sign1    = div_if.cmd_signed_i & div_if.op1_i[XLEN-1];
    assign sign2    = div_if.cmd_signed_i & div_if.op2_i[XLEN-1];
    assign mag1     = sign1 ? (~div_if.op1_i + 1'b1) : div_if.op1_i;
    assign mag2     = sign2 ? (~div_if.op2_i + 1'b1) : div_if.op2_i;
    assign div_zero = (div_if.op2_i == '0);
    assign ovf      = div_if.cmd_signed_i & (div_if.op1_i == MIN_NEG) & (div_if.op2_i == '1);

`ifdef RV_DIV_EARLY_OUT_EN
    logic small;
    assign small   = (mag1 < mag2);
    assign special = div_zero | ovf | small;
    assign early   = special;
`else
    assign special = div_zero | ovf;
    assign early   = 1'b0;
`endif

    always_comb begin
        forced_res = '0;
        if (div_zero) begin
            forced_res = div_if.cmd_div_mod_i ? div_if.op1_i : '1;
        end else if (ovf) begin
            forced_res = div_if.cmd_div_mod_i ? '0 : div_if.op1_i;
        end
`ifdef RV_DIV_EARLY_OUT_EN
        else if (small) begin
            forced_res = div_if.cmd_div_mod_i ? div_if.op1_i : '0;
        end
`endif
    end

    assign rem_chain[0] = rem_q;

    for (genvar j = 0; j < RADIX_BITS; j++) begin : g_step
        rv_div_step #(.XLEN(XLEN)) u_step (
            .rem_i     (rem_chain[j]),
            .dvd_msb_i (quo_q[XLEN-1-j]),
            .dvs_i     (dvs_q),
            .rem_o     (rem_chain[j+1]),
            .q_o       (q_bits[RADIX_BITS-1-j])
        );
    end

    assign quo_fix = neg_q  ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = rneg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        mod_d    = mod_q;
        forced_d = forced_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rem_d    = '0;
                    quo_d    = mag1;
                    dvs_d    = mag2;
                    cnt_d    = CNT_W'(N);
                    neg_d    = sign1 ^ sign2;
                    rneg_d   = sign1;
                    mod_d    = div_if.cmd_div_mod_i;
                    forced_d = special;
                    result_d = forced_res;
                    state_d  = early ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                // Dividend bits leave at the top of quo_q while quotient bits enter at the bottom.
                rem_d = rem_chain[RADIX_BITS];
                quo_d = {quo_q[XLEN-RADIX_BITS-1:0], q_bits};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!forced_q) begin
                    result_d = mod_q ? rem_fix : quo_fix;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (div_if.kill_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mod_q    <= 1'b0;
            forced_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            mod_q    <= mod_d;
            forced_q <= forced_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_rv_divider.sv
// Directed bench for rv_divider: radix 1, 2 and 4 instances side by side on one clock.
module tb_rv_divider;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rv_divider_if #(.XLEN(32)) if1 ();
    rv_divider_if #(.XLEN(32)) if2 ();
    rv_divider_if #(.XLEN(32)) if4 ();

    rv_divider #(.XLEN(32), .RADIX_BITS(1)) u_div1 (.clk_i(clk), .rst_i(rst), .div_if(if1.slave));
    rv_divider #(.XLEN(32), .RADIX_BITS(2)) u_div2 (.clk_i(clk), .rst_i(rst), .div_if(if2.slave));
    rv_divider #(.XLEN(32), .RADIX_BITS(4)) u_div4 (.clk_i(clk), .rst_i(rst), .div_if(if4.slave));

`ifdef RV_DIV_EARLY_OUT_EN
    localparam int LAT_TRIVIAL = 1;
`else
    localparam int LAT_TRIVIAL = 34;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic sgn, input logic md,
                         input logic kill, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            1: begin
                if1.valid_i = v; if1.cmd_div_i = v; if1.cmd_signed_i = sgn;
                if1.cmd_div_mod_i = md; if1.kill_i = kill; if1.op1_i = a; if1.op2_i = b;
            end
            2: begin
                if2.valid_i = v; if2.cmd_div_i = v; if2.cmd_signed_i = sgn;
                if2.cmd_div_mod_i = md; if2.kill_i = kill; if2.op1_i = a; if2.op2_i = b;
            end
            default: begin
                if4.valid_i = v; if4.cmd_div_i = v; if4.cmd_signed_i = sgn;
                if4.cmd_div_mod_i = md; if4.kill_i = kill; if4.op1_i = a; if4.op2_i = b;
            end
        endcase
    endtask

    task automatic sample(input int sel, output logic we, output logic busy,
                          output logic wt, output logic [31:0] res);
        case (sel)
            1:       begin we = if1.we_o; busy = if1.busy_o; wt = if1.wait_o; res = if1.result_o; end
            2:       begin we = if2.we_o; busy = if2.busy_o; wt = if2.wait_o; res = if2.result_o; end
            default: begin we = if4.we_o; busy = if4.busy_o; wt = if4.wait_o; res = if4.result_o; end
        endcase
    endtask

    // Issues one operation; lat counts cycles from the accept cycle to the we_o cycle.
    task automatic run_op(input int sel, input logic sgn, input logic md,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        logic we, bz, wt;
        logic [31:0] r;
        @(negedge clk);
        drive(sel, 1'b1, sgn, md, 1'b0, a, b);
        #1 sample(sel, we, bz, wt, r);
        check("accept_wait", {63'd0, wt}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 999;
        busy_ok = 1'b1;
        res = 32'hDEADBEEF;
        for (int k = 1; k <= 200; k++) begin
            #1 sample(sel, we, bz, wt, r);
            if (we) begin
                lat = k;
                res = r;
                break;
            end
            if (!bz) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic sgn, input logic md,
                                            input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : a;
            return md ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return md ? (a % b) : (a / b);
    endfunction

    initial begin
        logic [31:0] res, r, a, b;
        int          lat;
        logic        busy_ok, we, bz, wt, sgn, md, we_seen;

        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1 sample(1, we, bz, wt, r);
        check("reset_busy", {63'd0, bz}, 64'd0);
        check("reset_we", {63'd0, we}, 64'd0);
        check("reset_result", {32'd0, r}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic unsigned divide with latency and busy profile.
        run_op(1, 1'b0, 1'b0, 32'd100, 32'd7, res, lat, busy_ok);
        check("divu_100_7", {32'd0, res}, 64'd14);
        check("divu_latency", 64'(lat), 64'd34);
        check("divu_busy_held", {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
        #1 sample(1, we, bz, wt, r);
        check("after_done_busy", {63'd0, bz}, 64'd0);
        check("after_done_we", {63'd0, we}, 64'd0);
        check("after_done_result", {32'd0, r}, 64'd0);

        run_op(1, 1'b0, 1'b1, 32'd100, 32'd7, res, lat, busy_ok);
        check("remu_100_7", {32'd0, res}, 64'd2);

        // Signed cases.
        run_op(1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, res, lat, busy_ok);
        check("div_m7_2", {32'd0, res}, 64'hFFFF_FFFD);
        run_op(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, busy_ok);
        check("rem_m7_2", {32'd0, res}, 64'hFFFF_FFFF);
        run_op(1, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, res, lat, busy_ok);
        check("div_7_m2", {32'd0, res}, 64'hFFFF_FFFD);
        run_op(1, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, busy_ok);
        check("rem_7_m2", {32'd0, res}, 64'd1);

        // Divide by zero.
        run_op(1, 1'b0, 1'b0, 32'd5, 32'd0, res, lat, busy_ok);
        check("divu_by_zero", {32'd0, res}, 64'hFFFF_FFFF);
        check("divu_by_zero_lat", 64'(lat), 64'(LAT_TRIVIAL));
        run_op(1, 1'b0, 1'b1, 32'd5, 32'd0, res, lat, busy_ok);
        check("remu_by_zero", {32'd0, res}, 64'd5);
        run_op(1, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, res, lat, busy_ok);
        check("div_by_zero", {32'd0, res}, 64'hFFFF_FFFF);

        // Signed overflow.
        run_op(1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        check("div_ovf", {32'd0, res}, 64'h8000_0000);
        check("div_ovf_lat", 64'(lat), 64'(LAT_TRIVIAL));
        run_op(1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        check("rem_ovf", {32'd0, res}, 64'd0);

        // Dividend smaller than divisor.
        run_op(1, 1'b0, 1'b0, 32'd3, 32'd10, res, lat, busy_ok);
        check("divu_small", {32'd0, res}, 64'd0);
        check("divu_small_lat", 64'(lat), 64'(LAT_TRIVIAL));
        run_op(1, 1'b0, 1'b1, 32'd3, 32'd10, res, lat, busy_ok);
        check("remu_small", {32'd0, res}, 64'd3);

        // Kill 10 cycles into the operation.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        #1 sample(1, we, bz, wt, r);
        check("kill_busy_before", {63'd0, bz}, 64'd1);
        @(posedge clk);
        #1 sample(1, we, bz, wt, r);
        check("kill_busy_after", {63'd0, bz}, 64'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        we_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 sample(1, we, bz, wt, r);
            if (we) we_seen = 1'b1;
        end
        check("kill_no_we", {63'd0, we_seen}, 64'd0);
        run_op(1, 1'b0, 1'b0, 32'd9, 32'd3, res, lat, busy_ok);
        check("divu_after_kill", {32'd0, res}, 64'd3);

        // Request together with kill in IDLE is refused.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 32'd3);
        #1 sample(1, we, bz, wt, r);
        check("idle_kill_wait", {63'd0, wt}, 64'd0);
        @(posedge clk);
        #1 sample(1, we, bz, wt, r);
        check("idle_kill_busy", {63'd0, bz}, 64'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd77, 32'd5);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 sample(1, we, bz, wt, r);
        check("async_rst_busy", {63'd0, bz}, 64'd0);
        check("async_rst_we", {63'd0, we}, 64'd0);
        check("async_rst_result", {32'd0, r}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Radix 2.
        run_op(2, 1'b0, 1'b0, 32'd100, 32'd7, res, lat, busy_ok);
        check("r2_divu_100_7", {32'd0, res}, 64'd14);
        check("r2_latency", 64'(lat), 64'd18);
        run_op(2, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, res, lat, busy_ok);
        check("r2_div_m7_2", {32'd0, res}, 64'hFFFF_FFFD);
        run_op(2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, res, lat, busy_ok);
        check("r2_remu_max_16", {32'd0, res}, 64'hF);

        // Radix 4.
        run_op(4, 1'b0, 1'b0, 32'd1000, 32'd33, res, lat, busy_ok);
        check("r4_divu_1000_33", {32'd0, res}, 64'd30);
        check("r4_latency", 64'(lat), 64'd10);
        run_op(4, 1'b0, 1'b1, 32'd1000, 32'd33, res, lat, busy_ok);
        check("r4_remu_1000_33", {32'd0, res}, 64'd10);
        run_op(4, 1'b1, 1'b0, 32'h8000_0000, 32'd3, res, lat, busy_ok);
        check("r4_div_min_3", {32'd0, res}, 64'hD555_5556);
        run_op(4, 1'b1, 1'b1, 32'h8000_0000, 32'd3, res, lat, busy_ok);
        check("r4_rem_min_3", {32'd0, res}, 64'hFFFF_FFFE);

        // Kill during DONE masks we_o in the same cycle.
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd50, 32'd5);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        drive(4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        #1 sample(4, we, bz, wt, r);
        check("r4_kill_done_we", {63'd0, we}, 64'd0);
        check("r4_kill_done_busy", {63'd0, bz}, 64'd1);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 28);
            sgn = 1'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            run_op((i % 2 == 0) ? 2 : 4, sgn, md, a, b, res, lat, busy_ok);
            check("rand_result", {32'd0, res}, {32'd0, ref_div(sgn, md, a, b)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
